// File: rtl/ofs_pcie_ss_rd_req_splitter.sv
// Splits large DMA reads into PCIe MRd requests bounded by MAX_RD_REQ_BYTES
// alignment, tagging each from a bitmap-managed pool freed by the completion path.
module ofs_pcie_ss_rd_req_splitter #(
  parameter int MAX_RD_REQ_BYTES = 512,
  parameter int MAX_TAGS         = 256,
  parameter int ADDR_WIDTH       = 64,
  parameter int LEN_WIDTH        = 24,
  parameter int TAG_WIDTH        = $clog2(MAX_TAGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [10:0]           out_len_dw,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_last,
  input  logic                  tag_free_valid,
  input  logic [TAG_WIDTH-1:0]  tag_free_tag,
  output logic [TAG_WIDTH:0]    tags_in_use,
  output logic                  err_bad_free,
  output logic                  err_zero_len
);

  localparam int OFFW = $clog2(MAX_RD_REQ_BYTES);
  localparam logic [TAG_WIDTH:0] ONE = 1;

  typedef enum logic {IDLE, SPLIT} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [MAX_TAGS-1:0]   bitmap_q, bitmap_d;
  logic [TAG_WIDTH:0]    in_use_q, in_use_d;
  logic                  out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [10:0]           out_len_q, out_len_d;
  logic [TAG_WIDTH-1:0]  out_tag_q, out_tag_d;
  logic                  out_last_q, out_last_d;
  logic                  err_bad_q, err_bad_d;
  logic                  err_zero_q, err_zero_d;

  logic [LEN_WIDTH-1:0]  room, chunk;
  logic                  any_free, issue, is_last, accept, free_ok;
  logic [TAG_WIDTH-1:0]  alloc_tag;

  // Bytes left before the next MAX_RD_REQ_BYTES boundary
  assign room    = LEN_WIDTH'(MAX_RD_REQ_BYTES) - LEN_WIDTH'(cur_addr_q[OFFW-1:0]);
  assign chunk   = (rem_q < room) ? rem_q : room;
  assign is_last = (rem_q == chunk);

  assign req_ready = rst_n && (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign issue     = (state_q == SPLIT) && (!out_valid_q || out_ready) && any_free;
  assign free_ok   = tag_free_valid && bitmap_q[tag_free_tag];
  assign err_bad_d = tag_free_valid && !bitmap_q[tag_free_tag];

  // Lowest-index free tag; only registered bitmap state is visible, so a tag
  // freed this cycle becomes allocatable next cycle.
  always_comb begin
    any_free  = 1'b0;
    alloc_tag = '0;
    for (int i = MAX_TAGS-1; i >= 0; i--) begin
      if (!bitmap_q[i]) begin
        any_free  = 1'b1;
        alloc_tag = TAG_WIDTH'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    rem_d       = rem_q;
    out_valid_d = out_valid_q && !out_ready;
    out_addr_d  = out_addr_q;
    out_len_d   = out_len_q;
    out_tag_d   = out_tag_q;
    out_last_d  = out_last_q;
    err_zero_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_len == '0) begin
            err_zero_d = 1'b1;
          end else begin
            cur_addr_d = req_addr;
            rem_d      = req_len;
            state_d    = SPLIT;
          end
        end
      end
      SPLIT: begin
        if (issue) begin
          out_valid_d = 1'b1;
          out_addr_d  = cur_addr_q;
          out_len_d   = 11'(chunk >> 2);
          out_tag_d   = alloc_tag;
          out_last_d  = is_last;
          cur_addr_d  = cur_addr_q + ADDR_WIDTH'(chunk);
          rem_d       = rem_q - chunk;
          if (is_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bitmap_d = bitmap_q;
    if (issue)   bitmap_d[alloc_tag]    = 1'b1;
    if (free_ok) bitmap_d[tag_free_tag] = 1'b0;
    case ({issue, free_ok})
      2'b10:   in_use_d = in_use_q + ONE;
      2'b01:   in_use_d = in_use_q - ONE;
      default: in_use_d = in_use_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      rem_q       <= '0;
      bitmap_q    <= '0;
      in_use_q    <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_len_q   <= '0;
      out_tag_q   <= '0;
      out_last_q  <= 1'b0;
      err_bad_q   <= 1'b0;
      err_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      rem_q       <= rem_d;
      bitmap_q    <= bitmap_d;
      in_use_q    <= in_use_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_len_q   <= out_len_d;
      out_tag_q   <= out_tag_d;
      out_last_q  <= out_last_d;
      err_bad_q   <= err_bad_d;
      err_zero_q  <= err_zero_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_addr     = out_addr_q;
  assign out_len_dw   = out_len_q;
  assign out_tag      = out_tag_q;
  assign out_last     = out_last_q;
  assign tags_in_use  = in_use_q;
  assign err_bad_free = err_bad_q;
  assign err_zero_len = err_zero_q;

endmodule
